imem_fetch_ctrl: RTL

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

---
 rtl/imem_fetch_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
//   Fetches bursts of SRAM line pairs (two read ports sharing one read
//   enable) and hands them to the engine stage through a 2-entry output
//   FIFO with a valid/ready handshake.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for i_start
//   FETCH | issuing line-pair reads, gated by FIFO room
//   DRAIN | all pairs issued, waiting for the final transfer
//
// Ports
//   i_clock, i_reset                  clock, synchronous active-high reset
//   i_start, i_base_addr, i_num_pairs burst request (sampled together)
//   o_sram_ce, o_sram_addr1/2         shared read enable and port addresses
//   i_sram_rdata1/2                   read data, one cycle after o_sram_ce
//   o_eng_iMem_data1/2, o_out_valid   FIFO head presented downstream
//   i_out_ready                       downstream accept
//   o_busy, o_done                    burst in progress / completion pulse
module imem_fetch_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 240
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_num_pairs,
  output logic              o_sram_ce,
  output logic [ADDR_W-1:0] o_sram_addr1,
  output logic [ADDR_W-1:0] o_sram_addr2,
  input  logic [DATA_W-1:0] i_sram_rdata1,
  input  logic [DATA_W-1:0] i_sram_rdata2,
  output logic [DATA_W-1:0] o_eng_iMem_data1,
  output logic [DATA_W-1:0] o_eng_iMem_data2,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_next_addr;
  logic [ADDR_W-1:0] r_last_addr1;
  logic [ADDR_W-1:0] r_last_addr2;
  logic [ADDR_W-1:0] r_issue_left;
  logic [ADDR_W-1:0] r_xfer_left;
  logic              r_inflight;
  logic              r_done;

  logic [DATA_W-1:0] r_fifo1 [2];
  logic [DATA_W-1:0] r_fifo2 [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;

  logic              w_pop;
  logic              w_issue;
  logic              w_busy;
  logic              w_done_nxt;
  logic              w_launch;
  logic [2:0]        w_occ;
  logic              w_room;

  assign o_out_valid      = (r_count != 2'd0);
  assign o_eng_iMem_data1 = r_fifo1[r_rd_ptr];
  assign o_eng_iMem_data2 = r_fifo2[r_rd_ptr];
  assign w_pop            = o_out_valid & i_out_ready;

  // Occupancy once the in-flight read lands; a same-cycle pop frees a slot,
  // so one pair per cycle is sustained while the consumer keeps up.
  assign w_occ  = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_room = (w_occ < (3'd2 + {2'b00, w_pop}));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_busy      = 1'b0;
    w_done_nxt  = 1'b0;
    w_launch    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          if (i_num_pairs != '0) begin
            w_launch    = 1'b1;
            w_state_nxt = FETCH;
          end else begin
            w_done_nxt  = 1'b1;
          end
        end
      end
      FETCH: begin
        w_busy  = 1'b1;
        w_issue = w_room;
        if (w_issue && (r_issue_left == ADDR_W'(1))) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        w_busy = 1'b1;
        if (w_pop && (r_xfer_left == ADDR_W'(1))) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_sram_ce    = w_issue;
  assign o_sram_addr1 = w_issue ? r_next_addr : r_last_addr1;
  assign o_sram_addr2 = w_issue ? (r_next_addr + ADDR_W'(1)) : r_last_addr2;
  assign o_busy       = w_busy;
  assign o_done       = r_done;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_next_addr  <= '0;
      r_last_addr1 <= '0;
      r_last_addr2 <= '0;
      r_issue_left <= '0;
      r_xfer_left  <= '0;
      r_inflight   <= 1'b0;
      r_done       <= 1'b0;
      r_fifo1[0]   <= '0;
      r_fifo1[1]   <= '0;
      r_fifo2[0]   <= '0;
      r_fifo2[1]   <= '0;
      r_rd_ptr     <= 1'b0;
      r_wr_ptr     <= 1'b0;
      r_count      <= 2'd0;
    end else begin
      r_done     <= w_done_nxt;
      r_inflight <= w_issue;

      if (w_launch) begin
        r_next_addr  <= i_base_addr;
        r_issue_left <= i_num_pairs;
        r_xfer_left  <= i_num_pairs;
      end

      if (w_issue) begin
        r_last_addr1 <= r_next_addr;
        r_last_addr2 <= r_next_addr + ADDR_W'(1);
        r_next_addr  <= r_next_addr + ADDR_W'(2);
        r_issue_left <= r_issue_left - ADDR_W'(1);
      end

      if (w_pop) begin
        r_xfer_left <= r_xfer_left - ADDR_W'(1);
        r_rd_ptr    <= ~r_rd_ptr;
      end

      // On a full FIFO with push+pop, r_wr_ptr equals r_rd_ptr: the slot
      // being popped is the one refilled, which keeps order intact.
      if (r_inflight) begin
        r_fifo1[r_wr_ptr] <= i_sram_rdata1;
        r_fifo2[r_wr_ptr] <= i_sram_rdata2;
        r_wr_ptr          <= ~r_wr_ptr;
      end

      case ({r_inflight, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
